ready_packets: RTL and testbench
================================

READY_PACKETS -- requirements
Module: ready_packets

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning word width in bits.
REQ-002 SHALL have parameter DEPTH, default 512, meaning storage capacity in words (power of two).
REQ-003 SHALL have parameter CNT_W, default 10, meaning data_count width; must satisfy 2**CNT_W > DEPTH.
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port din, input, DATA_W bits: write data.
REQ-007 SHALL have port wr_en, input, 1 bit: write request.
REQ-008 SHALL have port rd_en, input, 1 bit: read request.
REQ-009 SHALL have port dout, output, DATA_W bits: read data, registered.
REQ-010 SHALL have port data_count, output, CNT_W bits: words currently stored.
REQ-011 SHALL have port empty, output, 1 bit: high when data_count==0.
REQ-012 SHALL have port full, output, 1 bit: high when data_count==DEPTH.

Function
REQ-013 SHALL be a synchronous single-clock FIFO; words leave in write order.
REQ-014 SHALL accept a write on a cycle with wr_en=1 and (full=0 or accepted read in the same cycle); din is stored at that edge.
REQ-015 SHALL accept a read on a cycle with rd_en=1 and empty=0; dout shows the head word after that edge (1-cycle read latency).
REQ-016 SHALL hold dout unchanged on cycles with no accepted read.
REQ-017 SHALL ignore wr_en while full with no read, and rd_en while empty; no state change, no data corruption.
REQ-018 SHALL, on simultaneous write and read: when empty, perform the write only; when full, perform both; otherwise perform both, data_count unchanged.
REQ-019 SHALL update data_count, empty and full registered at the same edge as the accepted operation: +1 for write-only, -1 for read-only.
REQ-020 SHALL wrap read and write pointers modulo DEPTH without loss.

Reset
REQ-021 SHALL, with reset=1 at a clock edge, set data_count=0, empty=1, full=0, dout=0, and both pointers to 0, overriding wr_en/rd_en that cycle.
REQ-022 SHALL discard all stored words on reset asserted mid-operation; stored RAM contents need not be cleared.

Configuration
REQ-023 SHALL, when READY_PACKETS_STATUS_EN is defined, add outputs overflow and underflow (1 bit each); overflow pulses one cycle after an ignored write, underflow one cycle after an ignored read; both reset to 0.
REQ-024 SHALL, without READY_PACKETS_STATUS_EN, omit those ports and their logic entirely; all other behaviour identical.

Structure
REQ-025 SHALL take default DATA_W, DEPTH and CNT_W constants from shared package ready_packets_pkg.
REQ-026 SHALL place storage in one sub-module ready_packets_ram (simple dual-port, synchronous write, registered read); pointer and count control in the top.

Verification
REQ-027 After reset: write 0x40,0x12,0x34 on consecutive cycles -> data_count 1,2,3; empty falls after first edge; three reads return 0x40,0x12,0x34, each one cycle after rd_en; empty=1 and data_count=0 at end.
REQ-028 Write 512 words 0..255 repeating -> full=1 at data_count=512; a 513th write with din=0xAA is ignored; readback returns 0..255,0..255 with no 0xAA.
REQ-029 Read while empty -> dout, data_count stay unchanged; underflow=1 for one cycle when READY_PACKETS_STATUS_EN defined.
REQ-030 Hold wr_en=rd_en=1 with 5 words stored for 1000 cycles -> data_count stays 5, pointers wrap, output sequence matches input order.
REQ-031 Simultaneous wr_en/rd_en when full -> read returns head word, new word stored, full stays 1; when empty -> only write performed, data_count=1.
REQ-032 Assert reset with 100 words stored and wr_en=1 -> next cycle data_count=0, empty=1, dout=0; first subsequent write/read returns the new word.

Source files
------------

// File: rtl/ready_packets_pkg.sv
// ready_packets_pkg: shared default sizes and the per-cycle operation encoding
// used by the ready_packets FIFO and its storage.
package ready_packets_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH = 512;
    localparam int DEF_CNT_W = 10;
    typedef enum logic [1:0] {OP_IDLE, OP_WRITE, OP_READ, OP_BOTH} fifoOp_t;
endpackage

// File: rtl/ready_packets_ram.sv
// ready_packets_ram: simple dual-port storage with synchronous write and a
// registered read port that holds its value when no read is requested.
module ready_packets_ram
    import ready_packets_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEF_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic              rdEn,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [DATA_W-1:0] rdData
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) mem[wrAddr] <= wrData;
    end

    // Read-before-write: a same-address read returns the old word, which is
    // what a simultaneous read/write on a full FIFO needs.
    always_ff @(posedge clk) begin
        if (reset) rdData <= '0;
        else if (rdEn) rdData <= mem[rdAddr];
    end
endmodule

// File: rtl/ready_packets.sv
// ready_packets: synchronous single-clock FIFO with registered count/flags.
// Define READY_PACKETS_STATUS_EN to add overflow/underflow pulse outputs.
module ready_packets
    import ready_packets_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  data_count,
    output logic              empty,
    output logic              full
`ifdef READY_PACKETS_STATUS_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] wrPtr, rdPtr;
    logic [CNT_W-1:0] countNext;
    logic doRead, doWrite;
    fifoOp_t op;

    // A read frees the slot a full-FIFO write needs, so the write qualifies on it.
    always_comb begin
        doRead = rd_en && !empty;
        doWrite = wr_en && (!full || doRead);
        op = doWrite ? (doRead ? OP_BOTH : OP_WRITE) : (doRead ? OP_READ : OP_IDLE);
        countNext = (op == OP_WRITE) ? data_count + CNT_W'(1) :
                    (op == OP_READ)  ? data_count - CNT_W'(1) : data_count;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            data_count <= '0;
            empty <= 1'b1;
            full <= 1'b0;
        end else begin
            wrPtr <= wrPtr + ADDR_W'(doWrite);
            rdPtr <= rdPtr + ADDR_W'(doRead);
            data_count <= countNext;
            empty <= countNext == '0;
            full <= countNext == CNT_W'(DEPTH);
        end
    end

`ifdef READY_PACKETS_STATUS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow <= wr_en && !doWrite;
            underflow <= rd_en && !doRead;
        end
    end
`endif

    ready_packets_ram #(
        .DATA_W(DATA_W),
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W)
    ) ram (
        .clk(clk),
        .reset(reset),
        .wrEn(doWrite),
        .wrAddr(wrPtr),
        .wrData(din),
        .rdEn(doRead),
        .rdAddr(rdPtr),
        .rdData(dout)
    );
endmodule

// File: tb/tb_ready_packets.sv
// tb_ready_packets: directed and randomized checks of ready_packets against a
// queue-based model of FIFO behaviour.
module tb_ready_packets;
    localparam int DEPTH = 512;

    logic clk = 0;
    logic reset = 0;
    logic [7:0] din = 0;
    logic wr_en = 0;
    logic rd_en = 0;
    logic [7:0] dout;
    logic [9:0] data_count;
    logic empty, full;
`ifdef READY_PACKETS_STATUS_EN
    logic overflow, underflow;
`endif

    ready_packets dut (
        .clk(clk),
        .reset(reset),
        .din(din),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .dout(dout),
        .data_count(data_count),
        .empty(empty),
        .full(full)
`ifdef READY_PACKETS_STATUS_EN
        ,
        .overflow(overflow),
        .underflow(underflow)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] q[$];
    logic [7:0] mDout = 0;
    logic mOver = 0;
    logic mUnder = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        check({tag, ".dout"}, 32'(dout), 32'(mDout));
        check({tag, ".count"}, 32'(data_count), 32'(q.size()));
        check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        check({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
`ifdef READY_PACKETS_STATUS_EN
        check({tag, ".overflow"}, 32'(overflow), 32'(mOver));
        check({tag, ".underflow"}, 32'(underflow), 32'(mUnder));
`endif
    endtask

    // One clock: drive, apply FIFO rules to the model, then compare.
    task automatic step(input logic w, input logic r, input logic [7:0] d, input string tag);
        logic canRead, canWrite;
        wr_en = w;
        rd_en = r;
        din = d;
        canRead = r && q.size() > 0;
        canWrite = w && (q.size() < DEPTH || canRead);
        @(posedge clk);
        #1;
        if (reset) begin
            q.delete();
            mDout = 0;
            mOver = 0;
            mUnder = 0;
        end else begin
            if (canRead) mDout = q.pop_front();
            if (canWrite) q.push_back(d);
            mOver = w && !canWrite;
            mUnder = r && !canRead;
        end
        checkAll(tag);
    endtask

    initial begin
        #1;
        reset = 1;
        step(0, 0, 8'h00, "reset");
        reset = 0;
        // basic write/read ordering
        step(1, 0, 8'h40, "wr40");
        step(1, 0, 8'h12, "wr12");
        step(1, 0, 8'h34, "wr34");
        check("count3", 32'(data_count), 32'd3);
        step(0, 1, 8'h00, "rd1");
        check("rd40", 32'(dout), 32'h40);
        step(0, 1, 8'h00, "rd2");
        step(0, 1, 8'h00, "rd3");
        check("rd34", 32'(dout), 32'h34);
        // read while empty
        step(0, 1, 8'h00, "rdEmpty");
        step(0, 0, 8'h00, "idleEmpty");
        // fill to full, ignored extra write
        for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(i), "fill");
        check("fullAt512", 32'(full), 32'd1);
        step(1, 0, 8'hAA, "wrFull");
        step(0, 0, 8'h00, "idleFull");
        step(1, 1, 8'h5C, "bothFull");
        for (int i = 0; i < DEPTH; i++) step(0, 1, 8'h00, "drain");
        check("drainEmpty", 32'(empty), 32'd1);
        step(1, 1, 8'h77, "bothEmpty");
        check("bothEmptyCnt", 32'(data_count), 32'd1);
        // steady simultaneous traffic at 5 words
        for (int i = 0; i < 4; i++) step(1, 0, 8'($urandom), "pre5");
        for (int i = 0; i < 1000; i++) step(1, 1, 8'($urandom), "stream");
        check("streamCnt", 32'(data_count), 32'd5);
        // reset mid-operation with 100 words and wr_en high
        for (int i = 0; i < 95; i++) step(1, 0, 8'($urandom), "to100");
        check("cnt100", 32'(data_count), 32'd100);
        reset = 1;
        step(1, 0, 8'hEE, "resetMid");
        reset = 0;
        step(1, 0, 8'h3C, "wrAfterRst");
        step(0, 1, 8'h00, "rdAfterRst");
        check("newWord", 32'(dout), 32'h3C);
        // randomized traffic
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50), 8'($urandom), "rand");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
